// File: rtl/mips_mem_defs_pkg.sv
// Shared op/state encodings and request-legality helpers for the load/store unit.
package mips_mem_defs;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W_BITS = 3;

    localparam logic [OP_W_BITS-1:0] OP_B  = 3'b000;
    localparam logic [OP_W_BITS-1:0] OP_H  = 3'b001;
    localparam logic [OP_W_BITS-1:0] OP_W  = 3'b010;
    localparam logic [OP_W_BITS-1:0] OP_BU = 3'b100;
    localparam logic [OP_W_BITS-1:0] OP_HU = 3'b101;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WAIT = 2'b10,
        WR   = 2'b11
    } lsuState_e;

    // Loads reject 011 and 11x; stores use only op[1:0] and reject 1xx and x11.
    function automatic logic opIllegal(input logic isStore, input logic [OP_W_BITS-1:0] op);
        if (isStore) begin
            return op[2] || (op[1:0] == 2'b11);
        end
        return (op[1:0] == 2'b11) || (op[2] && op[1]);
    endfunction

    function automatic logic addrMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        return ((size == SIZE_H) && addrLo[0]) || ((size == SIZE_W) && (addrLo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane steering: extracts/extends load data and merges sub-word store data.
module lsu_byte_lane
    import mips_mem_defs::*;
(
    input  logic [WORD_W-1:0]    rdata,
    input  logic [WORD_W-1:0]    wdata,
    input  logic [1:0]           lane,
    input  logic [OP_W_BITS-1:0] op,
    output logic [WORD_W-1:0]    loadVal,
    output logic [WORD_W-1:0]    mergeVal
);

    logic [WORD_W-1:0] shifted;
    logic [7:0]        byteVal;
    logic [15:0]       halfVal;

    // Extract: move the addressed lane to bit 0, then extend per op.
    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        byteVal = shifted[7:0];
        halfVal = shifted[15:0];
        case (op[1:0])
            SIZE_B:  loadVal = op[2] ? {24'b0, byteVal} : {{24{byteVal[7]}}, byteVal};
            SIZE_H:  loadVal = op[2] ? {16'b0, halfVal} : {{16{halfVal[15]}}, halfVal};
            default: loadVal = rdata;
        endcase
    end

    // Merge: overlay the right-aligned store data onto the old word at the addressed lane.
    always_comb begin
        mergeVal = rdata;
        if (op[1:0] == SIZE_B) begin
            case (lane)
                2'd0:    mergeVal[7:0]   = wdata[7:0];
                2'd1:    mergeVal[15:8]  = wdata[7:0];
                2'd2:    mergeVal[23:16] = wdata[7:0];
                default: mergeVal[31:24] = wdata[7:0];
            endcase
        end else if (op[1:0] == SIZE_H) begin
            if (lane[1]) begin
                mergeVal[31:16] = wdata[15:0];
            end else begin
                mergeVal[15:0] = wdata[15:0];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end for a word-only DataMemory: sub-word loads, read-modify-write
// sub-word stores, and misalignment/illegal-op rejection without memory access.
module load_store_unit
    import mips_mem_defs::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MEM_AW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [2:0]           req_op,
    input  logic [31:0]          req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic [DATA_W-1:0]    load_data,
    output logic                 done,
    output logic                 misalign,
    output logic [MEM_AW-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 mem_we,
    output logic                 mem_re
);

    lsuState_e          state;
    logic [2:0]         opReg;
    logic [31:0]        addrReg;
    logic               storeReg;
    logic [DATA_W-1:0]  wbuf;
    logic [DATA_W-1:0]  loadData;
    logic               doneReg;
    logic               misReg;
    logic [DATA_W-1:0]  laneLoad;
    logic [DATA_W-1:0]  laneMerge;
    logic               reqBad;

    assign reqBad = opIllegal(req_store, req_op) || addrMisaligned(req_op[1:0], req_addr[1:0]);

    lsu_byte_lane uLane (
        .rdata    (mem_rdata),
        .wdata    (wbuf),
        .lane     (addrReg[1:0]),
        .op       (opReg),
        .loadVal  (laneLoad),
        .mergeVal (laneMerge)
    );

    // wbuf holds the raw store data until WAIT replaces it with the merged word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            opReg    <= '0;
            addrReg  <= '0;
            storeReg <= 1'b0;
            wbuf     <= '0;
            loadData <= '0;
            doneReg  <= 1'b0;
            misReg   <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            misReg  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        opReg    <= req_op;
                        addrReg  <= req_addr;
                        storeReg <= req_store;
                        wbuf     <= req_wdata;
                        if (reqBad) begin
                            doneReg <= 1'b1;
                            misReg  <= 1'b1;
                        end else if (req_store && (req_op[1:0] == SIZE_W)) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: state <= WAIT;
                WAIT: begin
                    if (storeReg) begin
                        wbuf  <= laneMerge;
                        state <= WR;
                    end else begin
                        loadData <= laneLoad;
                        doneReg  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                WR: begin
                    doneReg <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign mem_re    = (state == RD);
    assign mem_we    = (state == WR);
    assign mem_addr  = MEM_AW'(addrReg[31:2]);
    assign mem_wdata = wbuf;
    assign load_data = loadData;
    assign done      = doneReg;
    assign misalign  = misReg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit driving a behavioural word-wide DataMemory.
module tb_load_store_unit;
    import mips_mem_defs::*;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        int          lat;
        int          acc;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] load_data;
    logic        done;
    logic        misalign;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_we;
    logic        mem_re;

    logic [31:0] mem [0:63];
    expEntry_t   sb[$];
    int          cyc = 0;
    int          vecs = 0;
    int          miscompares = 0;
    int          weCount = 0;
    int          reCount = 0;
    logic [31:0] lastWeAddr = 32'h0;

    load_store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .load_data (load_data),
        .done      (done),
        .misalign  (misalign),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DataMemory: synchronous write, read data registered for the following cycle.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[5:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                weCount++;
                lastWeAddr = mem_addr;
            end
            if (mem_re) reCount++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'h0);
                end else begin
                    expEntry_t e;
                    e = sb.pop_front();
                    check("load_data", load_data, e.data);
                    check("misalign", 32'(misalign), 32'(e.mis));
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] expData, input logic expMis,
                         input int lat, input bit track);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_store = st;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        if (track) sb.push_back('{expData, expMis, lat, cyc});
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        int weBefore;
        int reBefore;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        #12;
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_done", 32'(done), 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_re", 32'(mem_re), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load back
        weBefore = weCount;
        issue(1'b1, OP_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
        drain();
        check("sw_we_cycles", 32'(weCount - weBefore), 32'h1);
        check("sw_we_addr", lastWeAddr, 32'h4);
        check("sw_mem4", mem[4], 32'hDEADBEEF);
        issue(1'b0, OP_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1);
        drain();

        // Byte store (RMW) and signed/unsigned byte loads
        issue(1'b1, OP_B, 32'h11, 32'h000000AA, 32'hDEADBEEF, 1'b0, 4, 1'b1);
        drain();
        check("sb_mem4", mem[4], 32'hDEADAAEF);
        issue(1'b0, OP_B, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 1'b1);
        issue(1'b0, OP_BU, 32'h11, 32'h0, 32'h000000AA, 1'b0, 3, 1'b1);
        drain();

        // Halfword store and loads
        issue(1'b1, OP_H, 32'h12, 32'h00001234, 32'h000000AA, 1'b0, 4, 1'b1);
        drain();
        check("sh_mem4", mem[4], 32'h1234AAEF);
        issue(1'b0, OP_H, 32'h12, 32'h0, 32'h00001234, 1'b0, 3, 1'b1);
        issue(1'b0, OP_HU, 32'h10, 32'h0, 32'h0000AAEF, 1'b0, 3, 1'b1);
        issue(1'b0, OP_H, 32'h10, 32'h0, 32'hFFFFAAEF, 1'b0, 3, 1'b1);
        drain();

        // Misaligned and illegal requests: no memory traffic, load_data held
        weBefore = weCount;
        reBefore = reCount;
        issue(1'b0, OP_W, 32'h13, 32'h0, 32'hFFFFAAEF, 1'b1, 1, 1'b1);
        issue(1'b1, OP_H, 32'h11, 32'h5555, 32'hFFFFAAEF, 1'b1, 1, 1'b1);
        issue(1'b1, OP_BU, 32'h10, 32'h77, 32'hFFFFAAEF, 1'b1, 1, 1'b1);
        issue(1'b0, 3'b011, 32'h10, 32'h0, 32'hFFFFAAEF, 1'b1, 1, 1'b1);
        issue(1'b0, 3'b110, 32'h10, 32'h0, 32'hFFFFAAEF, 1'b1, 1, 1'b1);
        drain();
        check("mis_we_none", 32'(weCount - weBefore), 32'h0);
        check("mis_re_none", 32'(reCount - reBefore), 32'h0);
        check("mis_mem4", mem[4], 32'h1234AAEF);

        // Back-to-back: load issued in the cycle the store's done rises
        issue(1'b1, OP_W, 32'h20, 32'h00000001, 32'hFFFFAAEF, 1'b0, 2, 1'b1);
        issue(1'b0, OP_W, 32'h20, 32'h0, 32'h00000001, 1'b0, 3, 1'b1);
        drain();

        // Reset during WAIT of a byte RMW abandons the write silently
        weBefore = weCount;
        issue(1'b1, OP_B, 32'h21, 32'h000000AA, 32'h0, 1'b0, 4, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", 32'(req_ready), 32'h1);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_load_data", load_data, 32'h0);
        check("midrst_mem_we", 32'(mem_we), 32'h0);
        check("midrst_mem_re", 32'(mem_re), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_mem8", mem[8], 32'h00000001);
        check("midrst_no_write", 32'(weCount - weBefore), 32'h0);
        check("midrst_sb_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
